// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and word constants.
// Contents: fetch_state_t (PRIME/RUN/STALLED), INST_BYTES, DEFAULT_NOP_INST.
// Imported by the fetch unit, its interface and the IF/ID register.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    PRIME   = 2'd0,
    RUN     = 2'd1,
    STALLED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INST_BYTES       = 32'd4;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Bundle of fetch-stage signals between the fetch unit and its environment.
// master: fetch unit (drives IMEM_ADDR and the IF/ID outputs).
// slave: environment (drives STALL, BRANCH_*, IMEM_INST).
interface pc_fetch_unit_if;

  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic [31:0] IMEM_INST;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IFID_INST;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_PC4;
  logic        IFID_VALID;

  modport master (
    input  STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_INST,
    output IMEM_ADDR, IFID_INST, IFID_PC, IFID_PC4, IFID_VALID
  );

  modport slave (
    output STALL, BRANCH_TAKEN, BRANCH_TARGET, IMEM_INST,
    input  IMEM_ADDR, IFID_INST, IFID_PC, IFID_PC4, IFID_VALID
  );

endinterface

// File: rtl/pc_fetch_unit_ifid_reg.sv
// IF/ID pipeline register with hold and flush controls.
// Ports: clk, rst_n, hold, flush, in_inst/in_pc/in_valid, out_inst/out_pc/out_pc4/out_valid.
// Flush beats hold; an invalid capture loads a bubble and keeps the old PC.
module ifid_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        in_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic        out_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_inst  <= NOP_INST;
      out_pc    <= 32'd0;
      out_pc4   <= 32'd0;
      out_valid <= 1'b0;
    end else if (flush || (!hold && !in_valid)) begin
      // Bubble: PC fields keep their last value
      out_inst  <= NOP_INST;
      out_valid <= 1'b0;
    end else if (!hold) begin
      out_inst  <= in_inst;
      out_pc    <= in_pc;
      out_pc4   <= in_pc + INST_BYTES;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, prime/run/stall FSM, IF/ID register.
// Ports: CLK, RESET_N, bus (pc_fetch_unit_if.master).
// STALL freezes PC and IF/ID; BRANCH_TAKEN overrides STALL and re-primes.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST     = DEFAULT_NOP_INST
) (
  input  logic            CLK,
  input  logic            RESET_N,
  pc_fetch_unit_if.master bus
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  fpc, fpc_nxt;
  logic         fvalid, fvalid_nxt;
  logic [31:0]  ibuf, ibuf_nxt;
  logic         ifid_hold;
  logic         ifid_flush;
  logic [31:0]  ifid_inst_in;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= PRIME;
      pc     <= RESET_VECTOR;
      fpc    <= RESET_VECTOR;
      fvalid <= 1'b0;
      ibuf   <= NOP_INST;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      fpc    <= fpc_nxt;
      fvalid <= fvalid_nxt;
      ibuf   <= ibuf_nxt;
    end
  end

  // The memory keeps sampling IMEM_ADDR (= PC, one word ahead of FPC) while
  // stalled, so its output drifts to the next word. ibuf snapshots the word
  // for FPC on every RUN edge, including the edge that enters STALLED, and
  // the release edge takes the instruction from ibuf instead of the memory.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    fpc_nxt      = fpc;
    fvalid_nxt   = fvalid;
    ibuf_nxt     = ibuf;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_inst_in = bus.IMEM_INST;

    if (bus.BRANCH_TAKEN) begin
      pc_nxt     = bus.BRANCH_TARGET & ~32'd3;
      fvalid_nxt = 1'b0;
      ifid_flush = 1'b1;
      state_nxt  = PRIME;
    end else begin
      case (state)
        PRIME: begin
          fpc_nxt    = pc;
          fvalid_nxt = 1'b1;
          pc_nxt     = pc + INST_BYTES;
          ifid_flush = 1'b1;
          state_nxt  = RUN;
        end
        RUN: begin
          ibuf_nxt = bus.IMEM_INST;
          if (bus.STALL) begin
            ifid_hold = 1'b1;
            state_nxt = STALLED;
          end else begin
            fpc_nxt = pc;
            pc_nxt  = pc + INST_BYTES;
          end
        end
        STALLED: begin
          if (bus.STALL) begin
            ifid_hold = 1'b1;
          end else begin
            ifid_inst_in = ibuf;
            fpc_nxt      = pc;
            pc_nxt       = pc + INST_BYTES;
            state_nxt    = RUN;
          end
        end
        default: begin
          fvalid_nxt = 1'b0;
          ifid_flush = 1'b1;
          state_nxt  = PRIME;
        end
      endcase
    end
  end

  logic [31:0] ifid_inst, ifid_pc, ifid_pc4;
  logic        ifid_valid;

  ifid_reg #(
    .NOP_INST (NOP_INST)
  ) u_ifid_reg (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .hold      (ifid_hold),
    .flush     (ifid_flush),
    .in_inst   (ifid_inst_in),
    .in_pc     (fpc),
    .in_valid  (fvalid),
    .out_inst  (ifid_inst),
    .out_pc    (ifid_pc),
    .out_pc4   (ifid_pc4),
    .out_valid (ifid_valid)
  );

  assign bus.IMEM_ADDR  = pc;
  assign bus.IFID_INST  = ifid_inst;
  assign bus.IFID_PC    = ifid_pc;
  assign bus.IFID_PC4   = ifid_pc4;
  assign bus.IFID_VALID = ifid_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: two instances (reset vector 0 and a wrapping vector),
// each with a registered instruction memory returning A000_0000 + word index.
// Directed scenarios: reset, free run, stall, redirect, redirect+stall, wrap, async reset.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WRAP_VEC = 32'hFFFF_FFF8;

  logic CLK;
  logic RESET_N;
  int   checks;
  int   failures;

  pc_fetch_unit_if bus ();
  pc_fetch_unit_if bus2 ();

  pc_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .NOP_INST(NOP)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
  );

  pc_fetch_unit #(.RESET_VECTOR(WRAP_VEC)) dut_wrap (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered-read instruction memories
  initial begin
    bus.IMEM_INST  = 32'd0;
    bus2.IMEM_INST = 32'd0;
  end
  always @(posedge CLK) begin
    bus.IMEM_INST  <= 32'hA000_0000 + (bus.IMEM_ADDR >> 2);
    bus2.IMEM_INST <= 32'hA000_0000 + (bus2.IMEM_ADDR >> 2);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    RESET_N = 1'b0;
    bus.STALL = 1'b0;
    bus.BRANCH_TAKEN = 1'b0;
    bus.BRANCH_TARGET = 32'd0;
    bus2.STALL = 1'b0;
    bus2.BRANCH_TAKEN = 1'b0;
    bus2.BRANCH_TARGET = 32'd0;
    repeat (2) step();
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (bus.IFID_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.IFID_VALID); end
    checks++; if (bus.IFID_INST !== NOP) begin failures++; $display("FAIL reset_inst got=%h exp=%h", bus.IFID_INST, NOP); end
    checks++; if (bus.IFID_PC !== 32'd0 || bus.IFID_PC4 !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h/%h exp=0/0", bus.IFID_PC, bus.IFID_PC4); end
    checks++; if (bus.IMEM_ADDR !== 32'd0) begin failures++; $display("FAIL reset_imem_addr got=%h exp=0", bus.IMEM_ADDR); end
    checks++; if (bus2.IMEM_ADDR !== WRAP_VEC) begin failures++; $display("FAIL reset_vector got=%h exp=%h", bus2.IMEM_ADDR, WRAP_VEC); end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc;
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) begin
        checks++; if (bus.IFID_VALID !== 1'b0 || bus.IFID_INST !== NOP) begin failures++; $display("FAIL free_bubble got=%0b/%h exp=0/%h", bus.IFID_VALID, bus.IFID_INST, NOP); end
      end else begin
        exp_pc = 32'(4 * (i - 1));
        checks++; if (bus.IFID_VALID !== 1'b1 || bus.IFID_PC !== exp_pc) begin failures++; $display("FAIL free_pc[%0d] got=%0b/%h exp=1/%h", i, bus.IFID_VALID, bus.IFID_PC, exp_pc); end
        checks++; if (bus.IFID_INST !== 32'hA000_0000 + 32'(i - 1)) begin failures++; $display("FAIL free_inst[%0d] got=%h exp=%h", i, bus.IFID_INST, 32'hA000_0000 + 32'(i - 1)); end
        checks++; if (bus.IFID_PC4 !== exp_pc + 32'd4) begin failures++; $display("FAIL free_pc4[%0d] got=%h exp=%h", i, bus.IFID_PC4, exp_pc + 32'd4); end
      end
    end
  endtask

  task automatic test_stall();
    reset_dut();
    repeat (4) step();
    checks++; if (bus.IFID_PC !== 32'd8) begin failures++; $display("FAIL stall_setup got=%h exp=8", bus.IFID_PC); end
    bus.STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.IFID_PC !== 32'd8 || bus.IFID_VALID !== 1'b1 || bus.IFID_INST !== 32'hA000_0002) begin failures++; $display("FAIL stall_hold[%0d] got=%h/%0b/%h exp=8/1/a0000002", i, bus.IFID_PC, bus.IFID_VALID, bus.IFID_INST); end
      checks++; if (bus.IMEM_ADDR !== 32'd16) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=10", i, bus.IMEM_ADDR); end
    end
    bus.STALL = 1'b0;
    step();
    checks++; if (bus.IFID_PC !== 32'd12 || bus.IFID_INST !== 32'hA000_0003) begin failures++; $display("FAIL stall_rel0 got=%h/%h exp=c/a0000003", bus.IFID_PC, bus.IFID_INST); end
    step();
    checks++; if (bus.IFID_PC !== 32'd16 || bus.IFID_INST !== 32'hA000_0004) begin failures++; $display("FAIL stall_rel1 got=%h/%h exp=10/a0000004", bus.IFID_PC, bus.IFID_INST); end
    step();
    checks++; if (bus.IFID_PC !== 32'd20 || bus.IFID_INST !== 32'hA000_0005) begin failures++; $display("FAIL stall_rel2 got=%h/%h exp=14/a0000005", bus.IFID_PC, bus.IFID_INST); end
  endtask

  task automatic test_redirect();
    reset_dut();
    repeat (3) step();
    checks++; if (bus.IFID_PC !== 32'd4) begin failures++; $display("FAIL redir_setup got=%h exp=4", bus.IFID_PC); end
    bus.BRANCH_TAKEN = 1'b1;
    bus.BRANCH_TARGET = 32'h40;
    step();
    bus.BRANCH_TAKEN = 1'b0;
    checks++; if (bus.IFID_VALID !== 1'b0 || bus.IFID_INST !== NOP) begin failures++; $display("FAIL redir_bubble got=%0b/%h exp=0/%h", bus.IFID_VALID, bus.IFID_INST, NOP); end
    checks++; if (bus.IMEM_ADDR !== 32'h40) begin failures++; $display("FAIL redir_addr got=%h exp=40", bus.IMEM_ADDR); end
    step();
    checks++; if (bus.IFID_VALID !== 1'b0) begin failures++; $display("FAIL redir_prime got=%0b exp=0", bus.IFID_VALID); end
    step();
    checks++; if (bus.IFID_VALID !== 1'b1 || bus.IFID_PC !== 32'h40 || bus.IFID_INST !== 32'hA000_0010) begin failures++; $display("FAIL redir_target got=%0b/%h/%h exp=1/40/a0000010", bus.IFID_VALID, bus.IFID_PC, bus.IFID_INST); end
  endtask

  task automatic test_redirect_stall();
    reset_dut();
    repeat (3) step();
    bus.BRANCH_TAKEN = 1'b1;
    bus.STALL = 1'b1;
    bus.BRANCH_TARGET = 32'h23;
    step();
    bus.BRANCH_TAKEN = 1'b0;
    bus.STALL = 1'b0;
    checks++; if (bus.IMEM_ADDR !== 32'h20 || bus.IFID_VALID !== 1'b0) begin failures++; $display("FAIL rs_redirect got=%h/%0b exp=20/0", bus.IMEM_ADDR, bus.IFID_VALID); end
    repeat (2) step();
    checks++; if (bus.IFID_VALID !== 1'b1 || bus.IFID_PC !== 32'h20 || bus.IFID_INST !== 32'hA000_0008) begin failures++; $display("FAIL rs_target got=%0b/%h/%h exp=1/20/a0000008", bus.IFID_VALID, bus.IFID_PC, bus.IFID_INST); end
  endtask

  task automatic test_wrap();
    reset_dut();
    step();
    step();
    checks++; if (bus2.IFID_PC !== 32'hFFFF_FFF8 || bus2.IFID_VALID !== 1'b1) begin failures++; $display("FAIL wrap_pc0 got=%h/%0b exp=fffffff8/1", bus2.IFID_PC, bus2.IFID_VALID); end
    step();
    checks++; if (bus2.IFID_PC !== 32'hFFFF_FFFC || bus2.IFID_PC4 !== 32'd0) begin failures++; $display("FAIL wrap_pc1 got=%h/%h exp=fffffffc/0", bus2.IFID_PC, bus2.IFID_PC4); end
    checks++; if (bus2.IFID_INST !== 32'hDFFF_FFFF) begin failures++; $display("FAIL wrap_inst got=%h exp=dfffffff", bus2.IFID_INST); end
    step();
    checks++; if (bus2.IFID_PC !== 32'd0 || bus2.IFID_INST !== 32'hA000_0000) begin failures++; $display("FAIL wrap_pc2 got=%h/%h exp=0/a0000000", bus2.IFID_PC, bus2.IFID_INST); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    repeat (4) step();
    bus.STALL = 1'b1;
    repeat (2) step();
    #3;
    RESET_N = 1'b0;
    #1;
    checks++; if (bus.IFID_VALID !== 1'b0 || bus.IFID_INST !== NOP) begin failures++; $display("FAIL rmid_valid got=%0b/%h exp=0/%h", bus.IFID_VALID, bus.IFID_INST, NOP); end
    checks++; if (bus.IFID_PC !== 32'd0 || bus.IFID_PC4 !== 32'd0 || bus.IMEM_ADDR !== 32'd0) begin failures++; $display("FAIL rmid_pc got=%h/%h/%h exp=0/0/0", bus.IFID_PC, bus.IFID_PC4, bus.IMEM_ADDR); end
    bus.STALL = 1'b0;
    RESET_N = 1'b1;
    step();
    checks++; if (bus.IFID_VALID !== 1'b0 || bus.IMEM_ADDR !== 32'd4) begin failures++; $display("FAIL rmid_prime got=%0b/%h exp=0/4", bus.IFID_VALID, bus.IMEM_ADDR); end
    step();
    checks++; if (bus.IFID_VALID !== 1'b1 || bus.IFID_PC !== 32'd0 || bus.IFID_INST !== 32'hA000_0000) begin failures++; $display("FAIL rmid_first got=%0b/%h/%h exp=1/0/a0000000", bus.IFID_VALID, bus.IFID_PC, bus.IFID_INST); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
